// File: rtl/icb_pkg.sv
// Shared ICB definitions for the SRAM responder and its response FIFO.
// Response bundle and lane constants.
package icb_pkg;

    localparam int ICB_DATA_W = 32;
    localparam int ICB_MASK_W = ICB_DATA_W / 8;

    typedef struct packed {
        logic [ICB_DATA_W-1:0] rdata;
        logic                  err;
    } icb_rsp_t;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO of ICB responses.
// Push and pop on a full FIFO in the same cycle is allowed.
module icb_rsp_fifo
    import icb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  icb_rsp_t      push_data,
    input  logic          pop,
    output icb_rsp_t      pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    icb_rsp_t        slots [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = slots[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/icb_sram_responder.sv
// ICB slave backed by a byte-maskable single-port SRAM.
// Registered read stage plus in-order response FIFO with bypass.
module icb_sram_responder
    import icb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h1000_0000,
    parameter int                RSP_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icb_cmd_valid,
    output logic                  icb_cmd_ready,
    input  logic                  icb_cmd_read,
    input  logic [ADDR_W-1:0]     icb_cmd_addr,
    input  logic [DATA_W-1:0]     icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] icb_cmd_wmask,
    output logic                  icb_rsp_valid,
    input  logic                  icb_rsp_ready,
    output logic [DATA_W-1:0]     icb_rsp_rdata,
    output logic                  icb_rsp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] q;

    logic [ADDR_W-1:0] off;
    logic [IW-1:0]     idx;
    logic              cmd_err;
    logic              accept;
    logic              wr_en;
    logic              rd_en;

    logic              s1_valid;
    logic              s1_err;
    logic              s1_read;
    icb_rsp_t          s1_rsp;

    icb_rsp_t          head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       occ;

    // Wrap-around subtraction makes addresses below the base land out of range too.
    assign off     = icb_cmd_addr - BASE_ADDR;
    assign idx     = off[IW+1:2];
    assign cmd_err = (icb_cmd_addr[1:0] != 2'b00) || ((off >> (IW + 2)) != '0);

    assign accept = icb_cmd_valid && icb_cmd_ready;
    assign wr_en  = accept && !icb_cmd_read && !cmd_err;
    assign rd_en  = accept && icb_cmd_read && !cmd_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < ICB_MASK_W; i++) begin
                if (icb_cmd_wmask[i]) begin
                    mem[idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            q <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_read  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err  <= cmd_err;
                s1_read <= icb_cmd_read;
            end
        end
    end

    assign s1_rsp.rdata = (s1_read && !s1_err) ? q : '0;
    assign s1_rsp.err   = s1_err;

    // s1 goes straight out when nothing is queued ahead of it.
    assign fifo_pop  = !fifo_empty && icb_rsp_ready;
    assign fifo_push = s1_valid && !(fifo_empty && icb_rsp_ready)
                       && (!fifo_full || fifo_pop);

    icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (s1_rsp),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign occ           = {1'b0, fifo_cnt} + (CW + 1)'(s1_valid);
    assign icb_cmd_ready = occ < (CW + 1)'(RSP_DEPTH);

    assign icb_rsp_valid = fifo_empty ? s1_valid     : 1'b1;
    assign icb_rsp_rdata = fifo_empty ? s1_rsp.rdata : head.rdata;
    assign icb_rsp_err   = fifo_empty ? s1_rsp.err   : head.err;

endmodule

// File: tb/tb_icb_sram_responder.sv
// Self-checking bench for icb_sram_responder.
// Reference: word-array memory plus a queue of expected responses.
module tb_icb_sram_responder;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          RD    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    icb_sram_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .RSP_DEPTH   (RD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (cmd_valid),
        .icb_cmd_ready (cmd_ready),
        .icb_cmd_read  (cmd_read),
        .icb_cmd_addr  (cmd_addr),
        .icb_cmd_wdata (cmd_wdata),
        .icb_cmd_wmask (cmd_wmask),
        .icb_rsp_valid (rsp_valid),
        .icb_rsp_ready (rsp_ready),
        .icb_rsp_rdata (rsp_rdata),
        .icb_rsp_err   (rsp_err)
    );

    int          checks = 0;
    int          failures = 0;
    int          acc_count = 0;
    int          pop_count = 0;
    longint      cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    bit          rand_rdy = 1'b0;

    logic [31:0] mm [DEPTH];
    logic [32:0] exq [$];

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        logic [63:0] aa;
        aa = 64'(a);
        return (a[1:0] != 2'b00) || (aa < 64'(BASE))
               || (aa >= 64'(BASE) + 64'(DEPTH) * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [32:0] expect_rsp(input logic rd, input logic [31:0] a);
        if (addr_err(a)) return {32'h0, 1'b1};
        if (!rd) return 33'h0;
        return {mm[widx(a)], 1'b0};
    endfunction

    task automatic apply_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        int i;
        i = widx(a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) mm[i][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic rand_ready();
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = m;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            done = cmd_ready;
            @(posedge clk);
            #1;
            rand_ready();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout addr=%h", a);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rand_ready();
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        for (int t = 0; t < 100 && exq.size() != 0; t++) idle();
        chki("drain_empty", exq.size(), 0);
    endtask

    task automatic xact(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, output logic [31:0] rdata, output logic err);
        int pc;
        pc = pop_count;
        cmd(rd, a, wd, m);
        cmd_valid = 1'b0;
        for (int t = 0; t < 20 && pop_count == pc; t++) begin
            @(negedge clk);
            #1;
        end
        if (pop_count == pc) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout addr=%h", a);
        end
        rdata = last_rdata;
        err   = last_err;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    logic        e;
    int          b0;
    longint      c0;
    logic [31:0] ra;
    logic [31:0] rw;
    int          k;

    initial begin
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                logic [32:0] hd;
                @(negedge clk);
                if (rst) begin
                    exq.delete();
                end else begin
                    chkb("rsp_valid", rsp_valid, exq.size() != 0);
                    chkb("cmd_ready", cmd_ready, exq.size() < RD);
                    if (rsp_valid && exq.size() != 0) begin
                        hd = exq[0];
                        chkw("rsp_rdata", rsp_rdata, hd[32:1]);
                        chkb("rsp_err", rsp_err, hd[0]);
                        if (rsp_ready) begin
                            void'(exq.pop_front());
                            last_rdata = rsp_rdata;
                            last_err   = rsp_err;
                            pop_count++;
                        end
                    end
                    if (cmd_valid && cmd_ready) begin
                        exq.push_back(expect_rsp(cmd_read, cmd_addr));
                        if (!cmd_read && !addr_err(cmd_addr))
                            apply_write(cmd_addr, cmd_wdata, cmd_wmask);
                        acc_count++;
                    end
                end
            end
        join_none

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chkb("reset_rsp_valid", rsp_valid, 1'b0);
        chkb("reset_rsp_err", rsp_err, 1'b0);
        chkw("reset_rsp_rdata", rsp_rdata, 32'h0);
        chkb("reset_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        for (int i = 0; i < DEPTH; i++) cmd(1'b0, BASE + 32'(i * 4), $urandom, 4'hF);
        idle();

        xact(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, r, e);
        chkw("wr_rsp_rdata", r, 32'h0);
        chkb("wr_rsp_err", e, 1'b0);
        xact(1'b1, BASE + 32'h10, 32'h0, 4'h0, r, e);
        chkw("rd_deadbeef", r, 32'hDEAD_BEEF);
        chkb("rd_deadbeef_err", e, 1'b0);

        xact(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, r, e);
        xact(1'b0, BASE + 32'h20, 32'h1122_3344, 4'b0101, r, e);
        xact(1'b1, BASE + 32'h20, 32'h0, 4'h0, r, e);
        chkw("mask_merge", r, 32'hFF22_FF44);

        xact(1'b0, BASE + 32'h20, 32'h0000_0000, 4'h0, r, e);
        xact(1'b1, BASE + 32'h20, 32'h0, 4'h0, r, e);
        chkw("mask_zero_noop", r, 32'hFF22_FF44);

        xact(1'b1, BASE + 32'h2, 32'h0, 4'h0, r, e);
        chkb("misalign_err", e, 1'b1);
        chkw("misalign_rdata", r, 32'h0);

        xact(1'b0, BASE, 32'h0BAD_F00D, 4'hF, r, e);
        xact(1'b0, BASE + 32'(DEPTH * 4), 32'h1234_5678, 4'hF, r, e);
        chkb("oor_write_err", e, 1'b1);
        xact(1'b1, BASE, 32'h0, 4'h0, r, e);
        chkw("oor_sram_unchanged", r, 32'h0BAD_F00D);
        xact(1'b1, BASE - 32'h4, 32'h0, 4'h0, r, e);
        chkb("below_base_err", e, 1'b1);

        rsp_ready = 1'b0;
        b0 = acc_count;
        fork
            begin
                cmd(1'b1, BASE + 32'h10, 32'h0, 4'h0);
                cmd(1'b1, BASE + 32'h20, 32'h0, 4'h0);
                cmd(1'b1, BASE + 32'h10, 32'h0, 4'h0);
                cmd(1'b1, BASE + 32'h20, 32'h0, 4'h0);
                cmd_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge clk);
                #1;
                chki("bp_accepts", acc_count - b0, RD);
                chkb("bp_cmd_ready", cmd_ready, 1'b0);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();
        chki("bp_total", acc_count - b0, 4);
        chkw("bp_last", last_rdata, 32'hFF22_FF44);

        c0 = cyc;
        for (int i = 0; i < 64; i++) cmd(1'b0, BASE + 32'h100 + 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 64; i++) cmd(1'b1, BASE + 32'h100 + 32'(i * 4), 32'h0, 4'h0);
        chki("stream_cycles", int'(cyc - c0), 128);
        drain();

        xact(1'b0, BASE + 32'h30, 32'hA5A5_5A5A, 4'hF, r, e);
        rsp_ready = 1'b0;
        cmd(1'b1, BASE + 32'h10, 32'h0, 4'h0);
        cmd(1'b1, BASE + 32'h20, 32'h0, 4'h0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chkb("pre_rst_full", cmd_ready, 1'b0);
        chkb("pre_rst_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chkb("post_rst_valid", rsp_valid, 1'b0);
        chkb("post_rst_ready", cmd_ready, 1'b1);
        chkw("post_rst_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        xact(1'b1, BASE + 32'h30, 32'h0, 4'h0, r, e);
        chkw("rst_persist_a", r, 32'hA5A5_5A5A);
        xact(1'b1, BASE + 32'h10, 32'h0, 4'h0, r, e);
        chkw("rst_persist_b", r, 32'hDEAD_BEEF);

        rand_rdy = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            k  = int'($urandom_range(0, 15));
            ra = BASE + (32'($urandom_range(0, 255)) << 2);
            if (k == 0) ra = ra + 32'($urandom_range(1, 3));
            if (k == 1) ra = BASE + 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
            if (k == 2) ra = BASE - 32'h4;
            if (k == 3) ra = $urandom;
            rw = $urandom;
            cmd(1'($urandom_range(0, 1)), ra, rw, 4'($urandom));
        end
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
